tmds_encoder: RTL

Single-channel TMDS encoder: sequences the transition-minimizing stage `tm_choice` and adds DC-balance control and control-period token insertion. The running-disparity tally persists across video cycles and clears during blanking. One instance sits per colour channel (R, G, B) between the video timing/pixel pipeline and the 10:1 serializer. The output is registered with one cycle of latency.

---
 rtl/tmds_encoder.sv | 93 +++++++++
 1 files changed

// File: rtl/tmds_encoder.sv
// Single-channel TMDS encoder: transition minimizing, DC balancing and
// control-token insertion, with one registered cycle of latency.

module tm_choice (
    input  logic [7:0] data_in,
    output logic [8:0] q_m
);
    logic [3:0] n1;
    logic       use_xnor;
    logic [7:0] acc;

    always_comb begin
        n1       = 4'($countones(data_in));
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !data_in[0]);
        acc      = '0;
        acc[0]   = data_in[0];
        for (int i = 1; i < 8; i++) begin
            acc[i] = use_xnor ? ~(acc[i-1] ^ data_in[i])
                              :  (acc[i-1] ^ data_in[i]);
        end
        q_m = {~use_xnor, acc};
    end
endmodule

module tmds_encoder (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out,
    output logic [4:0] tally_out
);
    logic [8:0] q_m;
    logic [3:0] n1;
    logic [4:0] d10;
    logic [4:0] tally;
    logic [4:0] tally_nxt;
    logic [9:0] sym_nxt;
    logic       t_zero;
    logic       t_pos;
    logic       t_neg;
    logic       bal;
    logic       inv_case;

    tm_choice u_tm (
        .data_in (data_in),
        .q_m     (q_m)
    );

    // d10 is N1-N0 = 2*N1-8, kept mod 32 so it adds as 5-bit signed
    always_comb begin
        n1       = 4'($countones(q_m[7:0]));
        d10      = {n1, 1'b0} - 5'd8;
        t_zero   = (tally == 5'd0);
        t_neg    = tally[4];
        t_pos    = !t_zero && !t_neg;
        bal      = (n1 == 4'd4);
        inv_case = (t_pos && n1 > 4'd4) || (t_neg && n1 < 4'd4);
        sym_nxt  = '0;
        tally_nxt = '0;
        if (!ve_in) begin
            unique case (control_in)
                2'b00: sym_nxt = 10'h354;
                2'b01: sym_nxt = 10'h0AB;
                2'b10: sym_nxt = 10'h154;
                2'b11: sym_nxt = 10'h2AB;
            endcase
        end else if (t_zero || bal) begin
            sym_nxt   = {~q_m[8], q_m[8],
                         q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            tally_nxt = q_m[8] ? tally + d10 : tally - d10;
        end else if (inv_case) begin
            sym_nxt   = {1'b1, q_m[8], ~q_m[7:0]};
            tally_nxt = tally + {3'b0, q_m[8], 1'b0} - d10;
        end else begin
            sym_nxt   = {1'b0, q_m[8], q_m[7:0]};
            tally_nxt = tally - {3'b0, ~q_m[8], 1'b0} + d10;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tally    <= '0;
            tmds_out <= '0;
        end else begin
            tally    <= tally_nxt;
            tmds_out <= sym_nxt;
        end
    end

    assign tally_out = tally;
endmodule
